// File: rtl/hazard_stall_controller_if.sv
// rtl/hazard_stall_controller_if.sv - hazard inputs and pipeline control outputs of the stall controller
interface hazard_stall_controller_if #(
  parameter int CNT_W = 16
);
  logic [4:0]       id_rs1;
  logic [4:0]       id_rs2;
  logic             id_uses_rs1;
  logic             id_uses_rs2;
  logic [4:0]       ex_rd;
  logic             ex_mem_read;
  logic             ex_branch_taken;
  logic             mem_req;
  logic             mem_ready;
  logic             pc_write;
  logic             if_id_write;
  logic             if_id_flush;
  logic             id_ex_write;
  logic             id_ex_flush;
  logic             ex_mem_write;
  logic             mem_wb_flush;
  logic             halted;
  logic [CNT_W-1:0] stall_cycles;
  logic [CNT_W-1:0] flush_events;

  modport master (
    output id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_rd, ex_mem_read,
           ex_branch_taken, mem_req, mem_ready,
    input  pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush,
           ex_mem_write, mem_wb_flush, halted, stall_cycles, flush_events
  );

  modport slave (
    input  id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_rd, ex_mem_read,
           ex_branch_taken, mem_req, mem_ready,
    output pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush,
           ex_mem_write, mem_wb_flush, halted, stall_cycles, flush_events
  );
endinterface

// File: rtl/hazard_stall_controller.sv
// rtl/hazard_stall_controller.sv - 5-stage pipeline stall/flush sequencing with memory-wait watchdog
module hazard_stall_controller #(
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  hazard_stall_controller_if.slave hz
);
  localparam int WC_W = $clog2(MEM_TIMEOUT + 1) + 1;

  typedef enum logic [1:0] {RUN, MEM_WAIT, HALT} state_t;

  state_t           state;
  logic [WC_W-1:0]  wait_cnt;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  logic mem_stall;
  logic load_use;
  logic branch_flush;
  logic in_halt;

  assign in_halt   = (state == HALT);
  assign mem_stall = hz.mem_req & ~hz.mem_ready;
  assign load_use  = hz.ex_mem_read & (hz.ex_rd != 5'd0) &
                     ((hz.id_uses_rs1 & (hz.id_rs1 == hz.ex_rd)) |
                      (hz.id_uses_rs2 & (hz.id_rs2 == hz.ex_rd)));
  // A branch held in EX by a memory stall stays asserted and flushes on the release cycle.
  assign branch_flush = ~in_halt & ~mem_stall & hz.ex_branch_taken;

  always_comb begin
    hz.pc_write     = 1'b1;
    hz.if_id_write  = 1'b1;
    hz.if_id_flush  = 1'b0;
    hz.id_ex_write  = 1'b1;
    hz.id_ex_flush  = 1'b0;
    hz.ex_mem_write = 1'b1;
    hz.mem_wb_flush = 1'b0;
    if (in_halt) begin
      hz.pc_write     = 1'b0;
      hz.if_id_write  = 1'b0;
      hz.id_ex_write  = 1'b0;
      hz.ex_mem_write = 1'b0;
    end else if (mem_stall) begin
      hz.pc_write     = 1'b0;
      hz.if_id_write  = 1'b0;
      hz.id_ex_write  = 1'b0;
      hz.ex_mem_write = 1'b0;
      hz.mem_wb_flush = 1'b1;
    end else if (hz.ex_branch_taken) begin
      hz.if_id_flush  = 1'b1;
      hz.id_ex_flush  = 1'b1;
    end else if (load_use) begin
      hz.pc_write     = 1'b0;
      hz.if_id_write  = 1'b0;
      hz.id_ex_flush  = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= RUN;
      wait_cnt  <= '0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      case (state)
        RUN: begin
          if (mem_stall) begin
            state    <= MEM_WAIT;
            wait_cnt <= WC_W'(1);
          end
        end
        MEM_WAIT: begin
          if (mem_stall && (wait_cnt == WC_W'(MEM_TIMEOUT))) begin
            state <= HALT;
          end else if (mem_stall) begin
            wait_cnt <= wait_cnt + WC_W'(1);
          end else begin
            state    <= RUN;
            wait_cnt <= '0;
          end
        end
        default: state <= HALT;
      endcase
      if (!in_halt) begin
        if (!hz.pc_write && (stall_cnt != {CNT_W{1'b1}}))
          stall_cnt <= stall_cnt + CNT_W'(1);
        if (branch_flush && (flush_cnt != {CNT_W{1'b1}}))
          flush_cnt <= flush_cnt + CNT_W'(1);
      end
    end
  end

  assign hz.halted       = in_halt;
  assign hz.stall_cycles = stall_cnt;
  assign hz.flush_events = flush_cnt;
endmodule

// File: tb/tb_hazard_stall_controller.sv
// tb/tb_hazard_stall_controller.sv - directed self-checking bench for hazard_stall_controller
module tb_hazard_stall_controller;
  localparam int CNT_W = 4;
  localparam int MEM_TIMEOUT = 4;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_bad;

  hazard_stall_controller_if #(.CNT_W(CNT_W)) hz ();

  hazard_stall_controller #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .hz    (hz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    hz.id_rs1 = 5'd0; hz.id_rs2 = 5'd0;
    hz.id_uses_rs1 = 1'b0; hz.id_uses_rs2 = 1'b0;
    hz.ex_rd = 5'd0; hz.ex_mem_read = 1'b0; hz.ex_branch_taken = 1'b0;
    hz.mem_req = 1'b0; hz.mem_ready = 1'b0;
  endtask

  // control vector {pc_w, ifid_w, ifid_f, idex_w, idex_f, exmem_w, memwb_f}
  function automatic logic [6:0] ctl();
    return {hz.pc_write, hz.if_id_write, hz.if_id_flush, hz.id_ex_write,
            hz.id_ex_flush, hz.ex_mem_write, hz.mem_wb_flush};
  endfunction

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    #12;
    n_cmp++;
    if (ctl() !== 7'b1101010) begin
      n_bad++; $display("FAIL reset_ctl got %b want %b", ctl(), 7'b1101010);
    end
    n_cmp++;
    if ({hz.halted, hz.stall_cycles, hz.flush_events} !== '0) begin
      n_bad++; $display("FAIL reset_state got halted=%b stall=%0d flush=%0d want 0/0/0",
                        hz.halted, hz.stall_cycles, hz.flush_events);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
  endtask

  task automatic test_load_use();
    hz.ex_mem_read = 1'b1; hz.ex_rd = 5'd5;
    hz.id_rs1 = 5'd5; hz.id_rs2 = 5'd1; hz.id_uses_rs1 = 1'b1; hz.id_uses_rs2 = 1'b1;
    #1;
    n_cmp++;
    if (ctl() !== 7'b0001110) begin
      n_bad++; $display("FAIL load_use_ctl got %b want %b", ctl(), 7'b0001110);
    end
    step();
    idle_inputs();
    #1;
    n_cmp++;
    if (ctl() !== 7'b1101010 || hz.stall_cycles !== 4'd1) begin
      n_bad++; $display("FAIL load_use_after got ctl=%b stall=%0d want 1101010/1", ctl(), hz.stall_cycles);
    end
  endtask

  task automatic test_x0_load();
    hz.ex_mem_read = 1'b1; hz.ex_rd = 5'd0;
    hz.id_rs1 = 5'd0; hz.id_rs2 = 5'd0; hz.id_uses_rs1 = 1'b1; hz.id_uses_rs2 = 1'b1;
    #1;
    n_cmp++;
    if (ctl() !== 7'b1101010) begin
      n_bad++; $display("FAIL x0_ctl got %b want %b", ctl(), 7'b1101010);
    end
    step();
    n_cmp++;
    if (hz.stall_cycles !== 4'd1) begin
      n_bad++; $display("FAIL x0_stall got %0d want 1", hz.stall_cycles);
    end
    idle_inputs();
  endtask

  task automatic test_branch_load_use();
    hz.ex_mem_read = 1'b1; hz.ex_rd = 5'd7; hz.id_rs2 = 5'd7; hz.id_uses_rs2 = 1'b1;
    hz.ex_branch_taken = 1'b1;
    #1;
    n_cmp++;
    if (ctl() !== 7'b1111110) begin
      n_bad++; $display("FAIL branch_lu_ctl got %b want %b", ctl(), 7'b1111110);
    end
    step();
    idle_inputs();
    n_cmp++;
    if (hz.flush_events !== 4'd1 || hz.stall_cycles !== 4'd1) begin
      n_bad++; $display("FAIL branch_lu_cnt got flush=%0d stall=%0d want 1/1", hz.flush_events, hz.stall_cycles);
    end
  endtask

  task automatic test_zero_wait();
    hz.mem_req = 1'b1; hz.mem_ready = 1'b1;
    #1;
    n_cmp++;
    if (ctl() !== 7'b1101010) begin
      n_bad++; $display("FAIL zero_wait_ctl got %b want %b", ctl(), 7'b1101010);
    end
    step();
    idle_inputs();
    n_cmp++;
    if (hz.stall_cycles !== 4'd1) begin
      n_bad++; $display("FAIL zero_wait_stall got %0d want 1", hz.stall_cycles);
    end
  endtask

  task automatic test_mem_wait();
    hz.mem_req = 1'b1; hz.mem_ready = 1'b0; hz.ex_branch_taken = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_cmp++;
      if (ctl() !== 7'b0000001) begin
        n_bad++; $display("FAIL mem_wait_ctl cycle %0d got %b want %b", i, ctl(), 7'b0000001);
      end
      step();
    end
    hz.mem_ready = 1'b1;
    #1;
    n_cmp++;
    if (ctl() !== 7'b1111110) begin
      n_bad++; $display("FAIL mem_release_ctl got %b want %b", ctl(), 7'b1111110);
    end
    step();
    idle_inputs();
    #1;
    n_cmp++;
    if (ctl() !== 7'b1101010 || hz.stall_cycles !== 4'd4 || hz.flush_events !== 4'd2) begin
      n_bad++; $display("FAIL mem_wait_after got ctl=%b stall=%0d flush=%0d want 1101010/4/2",
                        ctl(), hz.stall_cycles, hz.flush_events);
    end
  endtask

  task automatic test_saturation();
    hz.ex_mem_read = 1'b1; hz.ex_rd = 5'd9; hz.id_rs1 = 5'd9; hz.id_uses_rs1 = 1'b1;
    for (int i = 0; i < 15; i++) step();
    n_cmp++;
    if (hz.stall_cycles !== 4'hF) begin
      n_bad++; $display("FAIL stall_sat got %0d want 15", hz.stall_cycles);
    end
    idle_inputs();
    hz.ex_branch_taken = 1'b1;
    for (int i = 0; i < 15; i++) step();
    n_cmp++;
    if (hz.flush_events !== 4'hF || hz.stall_cycles !== 4'hF) begin
      n_bad++; $display("FAIL flush_sat got flush=%0d stall=%0d want 15/15", hz.flush_events, hz.stall_cycles);
    end
    idle_inputs();
  endtask

  task automatic test_timeout();
    test_reset();
    hz.mem_req = 1'b1; hz.mem_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      n_cmp++;
      if (hz.halted !== 1'b0 || ctl() !== 7'b0000001) begin
        n_bad++; $display("FAIL timeout_wait cycle %0d got halted=%b ctl=%b want 0/0000001", i, hz.halted, ctl());
      end
      step();
    end
    n_cmp++;
    if (hz.halted !== 1'b1 || ctl() !== 7'b0000000 || hz.stall_cycles !== 4'd5) begin
      n_bad++; $display("FAIL timeout_halt got halted=%b ctl=%b stall=%0d want 1/0000000/5",
                        hz.halted, ctl(), hz.stall_cycles);
    end
    hz.mem_ready = 1'b1; hz.ex_branch_taken = 1'b1;
    for (int i = 0; i < 3; i++) step();
    n_cmp++;
    if (hz.halted !== 1'b1 || ctl() !== 7'b0000000 || hz.stall_cycles !== 4'd5 || hz.flush_events !== 4'd0) begin
      n_bad++; $display("FAIL halt_sticky got halted=%b ctl=%b stall=%0d flush=%0d want 1/0000000/5/0",
                        hz.halted, ctl(), hz.stall_cycles, hz.flush_events);
    end
    idle_inputs();
  endtask

  task automatic test_reset_mid_wait();
    test_reset();
    hz.mem_req = 1'b1; hz.mem_ready = 1'b0;
    step(); step();
    #2;
    reset = 1'b1;
    #1;
    n_cmp++;
    if (hz.halted !== 1'b0 || hz.stall_cycles !== 4'd0 || hz.flush_events !== 4'd0) begin
      n_bad++; $display("FAIL reset_mid_cnt got halted=%b stall=%0d flush=%0d want 0/0/0",
                        hz.halted, hz.stall_cycles, hz.flush_events);
    end
    hz.mem_req = 1'b0;
    #1;
    n_cmp++;
    if (ctl() !== 7'b1101010) begin
      n_bad++; $display("FAIL reset_mid_ctl got %b want %b", ctl(), 7'b1101010);
    end
    step();
    reset = 1'b0;
    hz.mem_req = 1'b1;
    for (int i = 0; i < 4; i++) step();
    n_cmp++;
    if (hz.halted !== 1'b0 || hz.stall_cycles !== 4'd4) begin
      n_bad++; $display("FAIL reset_mid_rewait got halted=%b stall=%0d want 0/4", hz.halted, hz.stall_cycles);
    end
    hz.mem_ready = 1'b1;
    step();
    idle_inputs();
    step();
    n_cmp++;
    if (hz.halted !== 1'b0 || ctl() !== 7'b1101010) begin
      n_bad++; $display("FAIL reset_mid_resume got halted=%b ctl=%b want 0/1101010", hz.halted, ctl());
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    reset = 1'b1;
    idle_inputs();
    test_reset();
    test_load_use();
    test_x0_load();
    test_branch_load_use();
    test_zero_wait();
    test_mem_wait();
    test_saturation();
    test_timeout();
    test_reset_mid_wait();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
